// File: rtl/nonogram_pkg.sv
// Shared types for the nonogram solver: line identifiers and the requeuer FSM states.
package nonogram_pkg;

  localparam int MAX_DIM    = 32;
  localparam int LINE_IDX_W = $clog2(MAX_DIM);

  typedef struct packed {
    logic                  is_row;
    logic [LINE_IDX_W-1:0] index;
  } line_id_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEED = 2'd1,
    SCAN = 2'd2,
    PUSH = 2'd3
  } requeue_state_t;

endpackage

// File: rtl/line_requeuer_lsb_finder.sv
// Combinational lowest-set-bit encoder; 'none' flags an all-zero vector.
module lsb_finder #(
  parameter int W  = 8,
  parameter int IW = (W > 1) ? $clog2(W) : 1
) (
  input  logic [W-1:0]  vec,
  output logic [IW-1:0] idx,
  output logic          none
);

  // Scan from the top down so the last hit written is the lowest set bit.
  always_comb begin
    idx  = '0;
    none = 1'b1;
    for (int i = W - 1; i >= 0; i--) begin
      if (vec[i]) begin
        idx  = IW'(i);
        none = 1'b0;
      end
    end
  end

endmodule

// File: rtl/line_requeuer.sv
// Producer end of the solver line queue: seeds every line on start, then requeues
// the crossing lines touched by each solver write-back, skipping lines already queued.
module line_requeuer
  import nonogram_pkg::*;
#(
  parameter int ROWS  = 10,
  parameter int COLS  = 10,
  parameter int DIM   = (ROWS > COLS) ? ROWS : COLS,
  parameter int IDX_W = $clog2(DIM)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             upd_valid,
  output logic             upd_ready,
  input  logic             upd_is_row,
  input  logic [IDX_W-1:0] upd_index,
  input  logic [DIM-1:0]   upd_changed,
  output logic             q_valid,
  input  logic             q_ready,
  output logic             q_is_row,
  output logic [IDX_W-1:0] q_index,
  input  logic             pop_valid,
  input  logic             pop_is_row,
  input  logic [IDX_W-1:0] pop_index,
  output logic             busy,
  output logic             quiescent
);

  localparam int LINES = ROWS + COLS;
  localparam int CTR_W = $clog2(LINES);

  // A row has COLS cells and a column has ROWS cells; bits beyond that are dropped.
  localparam logic [DIM-1:0] ROW_UPD_KEEP = {DIM{1'b1}} >> (DIM - COLS);
  localparam logic [DIM-1:0] COL_UPD_KEEP = {DIM{1'b1}} >> (DIM - ROWS);

  function automatic logic in_range(input logic is_row, input int idx);
    return is_row ? (idx < ROWS) : (idx < COLS);
  endfunction

  // Pending bitmap layout: rows at [ROWS-1:0], columns above them.
  function automatic logic [LINES-1:0] line_onehot(input logic is_row, input int idx);
    return is_row ? (LINES'(1) << idx) : (LINES'(1) << (ROWS + idx));
  endfunction

  requeue_state_t   state_q, state_d;
  logic [CTR_W-1:0] ctr_q, ctr_d;
  logic [DIM-1:0]   mask_q, mask_d;
  logic             cross_row_q, cross_row_d;
  logic [LINES-1:0] pending_q, pending_d;

  logic [IDX_W-1:0] lsb_idx;
  logic             lsb_none;
  logic [DIM-1:0]   lsb_onehot;
  line_id_t         push_id;
  logic [LINES-1:0] push_onehot;
  logic [LINES-1:0] set_vec;
  logic [LINES-1:0] clr_vec;

  lsb_finder #(
    .W  (DIM),
    .IW (IDX_W)
  ) u_lsb (
    .vec  (mask_q),
    .idx  (lsb_idx),
    .none (lsb_none)
  );

  assign lsb_onehot = DIM'(1) << lsb_idx;

  // The pushed id comes only from registers, so it cannot move while a push stalls.
  always_comb begin
    push_id = '0;
    if (state_q == SEED) begin
      if (int'(ctr_q) < ROWS) begin
        push_id.is_row = 1'b1;
        push_id.index  = LINE_IDX_W'(ctr_q);
      end else begin
        push_id.is_row = 1'b0;
        push_id.index  = LINE_IDX_W'(int'(ctr_q) - ROWS);
      end
    end else begin
      push_id.is_row = cross_row_q;
      push_id.index  = LINE_IDX_W'(lsb_idx);
    end
    push_onehot = line_onehot(push_id.is_row, int'(push_id.index));
  end

  // NOTE: every signal gets a default before the case so no path leaves it unassigned (no latches).
  always_comb begin
    state_d     = state_q;
    ctr_d       = ctr_q;
    mask_d      = mask_q;
    cross_row_d = cross_row_q;
    set_vec     = '0;

    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d = SEED;
          ctr_d   = '0;
        end else if (upd_valid && in_range(upd_is_row, int'(upd_index))) begin
          mask_d      = upd_changed & (upd_is_row ? ROW_UPD_KEEP : COL_UPD_KEEP);
          cross_row_d = ~upd_is_row;
          state_d     = SCAN;
        end
      end
      SEED: begin
        if (q_ready) begin
          set_vec = push_onehot;
          if (ctr_q == CTR_W'(LINES - 1)) state_d = IDLE;
          else                            ctr_d   = ctr_q + CTR_W'(1);
        end
      end
      SCAN: begin
        if (lsb_none)                         state_d = IDLE;
        else if (|(pending_q & push_onehot))  mask_d  = mask_q & ~lsb_onehot;
        else                                  state_d = PUSH;
      end
      PUSH: begin
        if (q_ready) begin
          set_vec = push_onehot;
          mask_d  = mask_q & ~lsb_onehot;
          state_d = SCAN;
        end
      end
      default: state_d = IDLE;
    endcase

    clr_vec = '0;
    if (pop_valid && in_range(pop_is_row, int'(pop_index)))
      clr_vec = line_onehot(pop_is_row, int'(pop_index));
    // Set is applied after clear so a same-cycle push of the popped line keeps it pending.
    pending_d = (pending_q & ~clr_vec) | set_vec;
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      ctr_q       <= '0;
      mask_q      <= '0;
      cross_row_q <= 1'b0;
      pending_q   <= '0;
    end else begin
      state_q     <= state_d;
      ctr_q       <= ctr_d;
      mask_q      <= mask_d;
      cross_row_q <= cross_row_d;
      pending_q   <= pending_d;
    end
  end

  // Outputs decode registered state, so reset drops q_valid without waiting for a clock.
  always_comb begin
    q_valid   = (state_q == SEED) || (state_q == PUSH);
    q_is_row  = push_id.is_row;
    q_index   = IDX_W'(push_id.index);
    busy      = (state_q != IDLE);
    quiescent = (state_q == IDLE) && (pending_q == '0);
    upd_ready = ~rst && (state_q == IDLE) && ~start;
  end

endmodule

// File: tb/tb_line_requeuer.sv
// Self-checking bench for line_requeuer on a 4x4 puzzle, against a queue-list reference model.
module tb_line_requeuer;

  localparam int ROWS  = 4;
  localparam int COLS  = 4;
  localparam int DIM   = 4;
  localparam int IDX_W = 2;
  localparam int LINES = ROWS + COLS;

  logic             clk = 1'b0;
  logic             rst;
  logic             start;
  logic             upd_valid;
  logic             upd_ready;
  logic             upd_is_row;
  logic [IDX_W-1:0] upd_index;
  logic [DIM-1:0]   upd_changed;
  logic             q_valid;
  logic             q_ready;
  logic             q_is_row;
  logic [IDX_W-1:0] q_index;
  logic             pop_valid;
  logic             pop_is_row;
  logic [IDX_W-1:0] pop_index;
  logic             busy;
  logic             quiescent;

  line_requeuer #(
    .ROWS (ROWS),
    .COLS (COLS)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .upd_valid   (upd_valid),
    .upd_ready   (upd_ready),
    .upd_is_row  (upd_is_row),
    .upd_index   (upd_index),
    .upd_changed (upd_changed),
    .q_valid     (q_valid),
    .q_ready     (q_ready),
    .q_is_row    (q_is_row),
    .q_index     (q_index),
    .pop_valid   (pop_valid),
    .pop_is_row  (pop_is_row),
    .pop_index   (pop_index),
    .busy        (busy),
    .quiescent   (quiescent)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  typedef struct {
    bit is_row;
    int index;
    int cyc;
  } push_t;

  push_t            obs[$];
  push_t            expq[$];
  int               exp_bc;
  bit [LINES-1:0]   mp;

  always @(posedge clk) cyc++;

  function automatic int lbit(input bit is_row, input int idx);
    return is_row ? idx : ROWS + idx;
  endfunction

  // Reference model of the queued set plus a log of accepted pushes.
  always @(negedge clk or posedge rst) begin
    if (rst) begin
      mp = '0;
    end else begin
      if (pop_valid) mp[lbit(pop_is_row, int'(pop_index))] = 1'b0;
      if (q_valid && q_ready) begin
        mp[lbit(q_is_row, int'(q_index))] = 1'b1;
        obs.push_back('{q_is_row, int'(q_index), cyc});
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Expected pushes: crossing lines in ascending order, in range, not already queued.
  task automatic build_expect(input bit is_row, input logic [DIM-1:0] mask);
    int lim;
    expq.delete();
    exp_bc = 1;
    lim = is_row ? COLS : ROWS;
    for (int j = 0; j < DIM; j++) begin
      if (mask[j] && j < lim) begin
        if (mp[lbit(!is_row, j)]) begin
          exp_bc += 1;
        end else begin
          expq.push_back('{!is_row, j, 0});
          exp_bc += 2;
        end
      end
    end
  endtask

  task automatic do_update(input bit is_row, input int idx, input logic [DIM-1:0] mask,
                           input bit rnd, output int bc);
    int w;
    w = 0;
    while (!upd_ready && w < 50) begin
      tick();
      w++;
    end
    upd_valid   = 1'b1;
    upd_is_row  = is_row;
    upd_index   = IDX_W'(idx);
    upd_changed = mask;
    tick();
    upd_valid = 1'b0;
    bc = 0;
    while (busy && bc < 200) begin
      if (rnd) q_ready = ($urandom_range(0, 3) != 0);
      tick();
      bc++;
    end
    q_ready = 1'b1;
  endtask

  task automatic pop_line(input bit is_row, input int idx);
    pop_valid  = 1'b1;
    pop_is_row = is_row;
    pop_index  = IDX_W'(idx);
    tick();
    pop_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) tick();
    n_checks++; if (q_valid !== 1'b0) begin n_fail++; $display("FAIL reset_q_valid: got %b want 0", q_valid); end
    n_checks++; if (upd_ready !== 1'b0) begin n_fail++; $display("FAIL reset_upd_ready: got %b want 0", upd_ready); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", busy); end
    n_checks++; if (quiescent !== 1'b1) begin n_fail++; $display("FAIL reset_quiescent: got %b want 1", quiescent); end
    rst = 1'b0;
    tick();
    n_checks++; if (upd_ready !== 1'b1) begin n_fail++; $display("FAIL post_reset_upd_ready: got %b want 1", upd_ready); end
  endtask

  task automatic test_seed();
    int bc;
    obs.delete();
    start = 1'b1;
    tick();
    start = 1'b0;
    bc = 0;
    while (busy && bc < 100) begin
      tick();
      bc++;
    end
    n_checks++; if (bc !== 8) begin n_fail++; $display("FAIL seed_cycles: got %0d want 8", bc); end
    n_checks++; if (obs.size() !== 8) begin n_fail++; $display("FAIL seed_count: got %0d want 8", obs.size()); end
    for (int i = 0; i < obs.size() && i < 8; i++) begin
      n_checks++;
      if (obs[i].is_row !== (i < ROWS) || obs[i].index !== i % ROWS || obs[i].cyc - obs[0].cyc !== i) begin
        n_fail++;
        $display("FAIL seed_push%0d: got row=%0b idx=%0d dcyc=%0d want row=%0b idx=%0d dcyc=%0d",
                 i, obs[i].is_row, obs[i].index, obs[i].cyc - obs[0].cyc, i < ROWS, i % ROWS, i);
      end
    end
    n_checks++; if (dut.pending_q !== 8'hFF) begin n_fail++; $display("FAIL seed_pending: got %h want ff", dut.pending_q); end
    n_checks++; if (quiescent !== 1'b0) begin n_fail++; $display("FAIL seed_quiescent: got %b want 0", quiescent); end
  endtask

  task automatic test_backpressure();
    int bc;
    obs.delete();
    q_ready = 1'b1;
    start   = 1'b1;
    tick();
    start = 1'b0;
    tick();
    tick();
    q_ready = 1'b0;
    for (int k = 0; k < 5; k++) begin
      n_checks++;
      if (q_valid !== 1'b1 || q_is_row !== 1'b1 || q_index !== 2'd2) begin
        n_fail++;
        $display("FAIL bp_hold%0d: got v=%b row=%b idx=%0d want v=1 row=1 idx=2", k, q_valid, q_is_row, q_index);
      end
      tick();
    end
    q_ready = 1'b1;
    bc = 0;
    while (busy && bc < 100) begin
      tick();
      bc++;
    end
    n_checks++; if (obs.size() !== 8) begin n_fail++; $display("FAIL bp_count: got %0d want 8", obs.size()); end
    for (int i = 0; i < obs.size() && i < 8; i++) begin
      n_checks++;
      if (obs[i].is_row !== (i < ROWS) || obs[i].index !== i % ROWS) begin
        n_fail++;
        $display("FAIL bp_push%0d: got row=%0b idx=%0d want row=%0b idx=%0d",
                 i, obs[i].is_row, obs[i].index, i < ROWS, i % ROWS);
      end
    end
  endtask

  task automatic test_requeue();
    int bc;
    for (int i = 0; i < LINES; i++) pop_line(i < ROWS, i % ROWS);
    tick();
    n_checks++; if (quiescent !== 1'b1) begin n_fail++; $display("FAIL rq_drained_quiescent: got %b want 1", quiescent); end
    obs.delete();
    build_expect(1'b1, 4'b1010);
    do_update(1'b1, 2, 4'b1010, 1'b0, bc);
    n_checks++; if (obs.size() !== 2) begin n_fail++; $display("FAIL rq_count: got %0d want 2", obs.size()); end
    for (int i = 0; i < obs.size() && i < expq.size(); i++) begin
      n_checks++;
      if (obs[i].is_row !== expq[i].is_row || obs[i].index !== expq[i].index) begin
        n_fail++;
        $display("FAIL rq_push%0d: got row=%0b idx=%0d want row=%0b idx=%0d",
                 i, obs[i].is_row, obs[i].index, expq[i].is_row, expq[i].index);
      end
    end
    n_checks++; if (bc !== 5) begin n_fail++; $display("FAIL rq_cycles: got %0d want 5", bc); end
    n_checks++; if (dut.pending_q !== 8'hA0) begin n_fail++; $display("FAIL rq_pending: got %h want a0", dut.pending_q); end
    n_checks++; if (quiescent !== 1'b0) begin n_fail++; $display("FAIL rq_quiescent: got %b want 0", quiescent); end
  endtask

  task automatic test_dedup();
    int bc;
    obs.delete();
    build_expect(1'b1, 4'b0011);
    do_update(1'b1, 0, 4'b0011, 1'b0, bc);
    n_checks++; if (obs.size() !== 1) begin n_fail++; $display("FAIL dedup_count: got %0d want 1", obs.size()); end
    if (obs.size() > 0) begin
      n_checks++;
      if (obs[0].is_row !== 1'b0 || obs[0].index !== 0) begin
        n_fail++;
        $display("FAIL dedup_push: got row=%0b idx=%0d want row=0 idx=0", obs[0].is_row, obs[0].index);
      end
    end
    n_checks++; if (bc !== exp_bc || bc !== 4) begin n_fail++; $display("FAIL dedup_cycles: got %0d want 4", bc); end
  endtask

  task automatic test_same_cycle();
    int  n;
    bit  popped;
    int  bc;
    pop_line(1'b0, 0);
    obs.delete();
    upd_valid   = 1'b1;
    upd_is_row  = 1'b1;
    upd_index   = 2'd1;
    upd_changed = 4'b0001;
    tick();
    upd_valid = 1'b0;
    n = 0;
    popped = 1'b0;
    while (busy && n < 50) begin
      if (!popped && q_valid && !q_is_row && q_index == 2'd0) begin
        pop_valid  = 1'b1;
        pop_is_row = 1'b0;
        pop_index  = 2'd0;
        popped     = 1'b1;
      end
      tick();
      pop_valid = 1'b0;
      n++;
    end
    n_checks++; if (popped !== 1'b1 || obs.size() !== 1) begin n_fail++; $display("FAIL same_push_seen: got popped=%0b pushes=%0d want 1 1", popped, obs.size()); end
    n_checks++; if (dut.pending_q[ROWS] !== 1'b1) begin n_fail++; $display("FAIL same_set_wins: got %b want 1", dut.pending_q[ROWS]); end

    obs.delete();
    do_update(1'b1, 3, 4'b0000, 1'b0, bc);
    n_checks++; if (obs.size() !== 0) begin n_fail++; $display("FAIL zero_mask_pushes: got %0d want 0", obs.size()); end
    n_checks++; if (bc !== 1) begin n_fail++; $display("FAIL zero_mask_cycles: got %0d busy cycles want 1", bc); end
    n_checks++; if (upd_ready !== 1'b1) begin n_fail++; $display("FAIL zero_mask_ready: got %b want 1", upd_ready); end
  endtask

  task automatic test_random();
    int bc;
    bit is_row;
    int idx;
    logic [DIM-1:0] mask;
    for (int it = 0; it < 24; it++) begin
      for (int p = $urandom_range(0, 3); p > 0; p--) pop_line($urandom_range(0, 1), $urandom_range(0, 3));
      is_row = $urandom_range(0, 1);
      idx    = $urandom_range(0, 3);
      mask   = DIM'($urandom);
      obs.delete();
      build_expect(is_row, mask);
      do_update(is_row, idx, mask, 1'b1, bc);
      n_checks++; if (bc >= 200) begin n_fail++; $display("FAIL rnd%0d_timeout: busy for %0d cycles", it, bc); end
      n_checks++; if (obs.size() !== expq.size()) begin n_fail++; $display("FAIL rnd%0d_count: got %0d want %0d", it, obs.size(), expq.size()); end
      for (int i = 0; i < obs.size() && i < expq.size(); i++) begin
        n_checks++;
        if (obs[i].is_row !== expq[i].is_row || obs[i].index !== expq[i].index) begin
          n_fail++;
          $display("FAIL rnd%0d_push%0d: got row=%0b idx=%0d want row=%0b idx=%0d",
                   it, i, obs[i].is_row, obs[i].index, expq[i].is_row, expq[i].index);
        end
      end
      n_checks++; if (dut.pending_q !== mp) begin n_fail++; $display("FAIL rnd%0d_pending: got %h want %h", it, dut.pending_q, mp); end
      n_checks++; if (quiescent !== (mp == '0)) begin n_fail++; $display("FAIL rnd%0d_quiescent: got %b want %b", it, quiescent, mp == '0); end
    end
  endtask

  task automatic test_reset_mid_push();
    int n;
    pop_line(1'b0, 2);
    q_ready     = 1'b0;
    upd_valid   = 1'b1;
    upd_is_row  = 1'b1;
    upd_index   = 2'd3;
    upd_changed = 4'b0100;
    tick();
    upd_valid = 1'b0;
    n = 0;
    while (!q_valid && n < 20) begin
      tick();
      n++;
    end
    n_checks++; if (q_valid !== 1'b1) begin n_fail++; $display("FAIL rmp_stalled: got %b want 1", q_valid); end
    #2;
    rst = 1'b1;
    #1;
    n_checks++; if (q_valid !== 1'b0) begin n_fail++; $display("FAIL rmp_async_drop: got %b want 0", q_valid); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rmp_busy: got %b want 0", busy); end
    tick();
    rst     = 1'b0;
    q_ready = 1'b1;
    tick();
    n_checks++; if (quiescent !== 1'b1) begin n_fail++; $display("FAIL rmp_quiescent: got %b want 1", quiescent); end
    n_checks++; if (upd_ready !== 1'b1) begin n_fail++; $display("FAIL rmp_upd_ready: got %b want 1", upd_ready); end
    n_checks++; if (q_valid !== 1'b0) begin n_fail++; $display("FAIL rmp_q_valid: got %b want 0", q_valid); end
  endtask

  initial begin
    rst         = 1'b1;
    start       = 1'b0;
    upd_valid   = 1'b0;
    upd_is_row  = 1'b0;
    upd_index   = '0;
    upd_changed = '0;
    q_ready     = 1'b1;
    pop_valid   = 1'b0;
    pop_is_row  = 1'b0;
    pop_index   = '0;
    test_reset();
    test_seed();
    test_backpressure();
    test_requeue();
    test_dedup();
    test_same_cycle();
    test_random();
    test_reset_mid_push();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog expired");
  end

endmodule
